// File: rtl/lsu_pkg.sv
// Shared load/store definitions: access sizes, request record and byte-enable patterns.
// Imported by the data-memory arbiter, the core LSU and the debug loader.
package lsu_pkg;

    localparam int LSU_WIDTH = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } mem_size_e;

    typedef struct packed {
        logic                 we;
        logic [LSU_WIDTH-1:0] addr;
        mem_size_e            size;
        logic                 uns;
        logic [LSU_WIDTH-1:0] wdata;
    } lsu_req_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H    = 4'b0011;
    localparam logic [3:0] BE_W    = 4'b1111;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per requester port.
// The requester drives the request fields and receives grant plus registered response.
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [1:0]       size;
    logic             uns;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             err;

    modport master (
        output req, we, addr, size, uns, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, size, uns, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter_lane.sv
// Byte-lane logic for one access: legality, byte enables, store replication and
// load extract/extend. Purely combinational; illegal accesses produce no enables.
module dmem_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic        legal,
    output logic [3:0]  byteen,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        legal     = 1'b0;
        byteen    = BE_NONE;
        wdata_rep = '0;
        rdata_ext = '0;
        shifted   = mem_rdata >> {addr_lo, 3'b000};
        case (size)
            SZ_B: begin
                legal     = 1'b1;
                byteen    = BE_B << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~uns & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                legal     = ~addr_lo[0];
                byteen    = legal ? (BE_H << {addr_lo[1], 1'b0}) : BE_NONE;
                wdata_rep = legal ? {2{wdata[15:0]}} : '0;
                rdata_ext = {{16{~uns & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                legal     = (addr_lo == 2'b00);
                byteen    = legal ? BE_W : BE_NONE;
                wdata_rep = legal ? wdata : '0;
                // Only consumed when aligned, where the shift is zero.
                rdata_ext = shifted;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-addressed data memory between the core (c)
// and debug (d) byte-addressed requesters, with a one-cycle registered response.
module dmem_arbiter
    import lsu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     c,
    dmem_arbiter_if.slave     d,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WIDTH-3:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [3:0]        mem_byteen,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam int NPORT = 2;

    lsu_req_t   port_req [NPORT];
    logic [1:0] port_act;
    logic [1:0] port_gnt;
    lsu_req_t   g_req;
    logic       any_gnt;
    logic       prio_q, prio_d;

    logic        lane_legal;
    logic [3:0]  lane_byteen;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign port_req[0] = '{we: c.we, addr: c.addr, size: mem_size_e'(c.size),
                           uns: c.uns, wdata: c.wdata};
    assign port_req[1] = '{we: d.we, addr: d.addr, size: mem_size_e'(d.size),
                           uns: d.uns, wdata: d.wdata};
    assign port_act    = {d.req, c.req};

    // prio names the winner of the next contended cycle (0 = core, 1 = debug).
    always_comb begin
        port_gnt = 2'b00;
        if (!rst) begin
            port_gnt[0] = port_act[0] & (~port_act[1] | ~prio_q);
            port_gnt[1] = port_act[1] & (~port_act[0] |  prio_q);
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (!rst && (port_act == 2'b11)) begin
            prio_d = ~prio_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign any_gnt = |port_gnt;
    assign g_req   = port_gnt[1] ? port_req[1] : port_req[0];

    dmem_lane u_lane (
        .addr_lo   (g_req.addr[1:0]),
        .size      (g_req.size),
        .uns       (g_req.uns),
        .wdata     (g_req.wdata),
        .mem_rdata (mem_rdata),
        .legal     (lane_legal),
        .byteen    (lane_byteen),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    always_comb begin
        mem_read   = any_gnt & lane_legal & ~g_req.we;
        mem_write  = any_gnt & lane_legal &  g_req.we;
        // Decoded and pass-through word-address segments are both forwarded as-is.
        mem_addr   = any_gnt ? {g_req.addr[WIDTH-1:MEM_AW+2], g_req.addr[MEM_AW+1:2]} : '0;
        mem_wdata  = any_gnt ? lane_wdata  : '0;
        mem_byteen = any_gnt ? lane_byteen : BE_NONE;
    end

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_resp
            logic             rvalid_q, rvalid_d;
            logic             err_q, err_d;
            logic [WIDTH-1:0] rdata_q, rdata_d;

            always_comb begin
                rvalid_d = port_gnt[gi];
                err_d    = port_gnt[gi] & ~lane_legal;
                rdata_d  = (port_gnt[gi] & lane_legal & ~g_req.we) ? lane_rdata : '0;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= rvalid_d;
                    err_q    <= err_d;
                    rdata_q  <= rdata_d;
                end
            end
        end
    endgenerate

    assign c.gnt    = port_gnt[0];
    assign c.rvalid = g_resp[0].rvalid_q;
    assign c.err    = g_resp[0].err_q;
    assign c.rdata  = g_resp[0].rdata_q;
    assign d.gnt    = port_gnt[1];
    assign d.rvalid = g_resp[1].rvalid_q;
    assign d.err    = g_resp[1].err_q;
    assign d.rdata  = g_resp[1].rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus randomized traffic checked
// against a byte-array memory model and a round-robin turn model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.WIDTH(32)) c_if ();
    dmem_arbiter_if #(.WIDTH(32)) d_if ();

    logic        mem_read, mem_write;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;

    dmem_arbiter #(.WIDTH(32), .MEM_AW(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .c          (c_if),
        .d          (d_if),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_rdata  (mem_rdata)
    );

    // Environment memory behind the arbiter.
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_write) begin
            for (int k = 0; k < 4; k++)
                if (mem_byteen[k]) mem[mem_addr[9:0]][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    // Reference memory as plain bytes, aliased on the low 12 address bits.
    logic [7:0] ref_mem [0:4095];

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } rq_t;

    int n_vec  = 0;
    int n_fail = 0;

    logic        o_cg, o_dg, o_rd, o_wr;
    logic [29:0] o_addr;
    logic [31:0] o_wd;
    logic [3:0]  o_be;
    logic        o_crv, o_cerr, o_drv, o_derr;
    logic [31:0] o_crd, o_drd;

    function automatic rq_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata);
        rq_t r;
        r.we = we; r.addr = addr; r.size = size; r.uns = uns; r.wdata = wdata;
        return r;
    endfunction

    function automatic bit legal_of(input rq_t r);
        case (r.size)
            2'd0:    return 1'b1;
            2'd1:    return r.addr[0] == 1'b0;
            2'd2:    return r.addr[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input rq_t r);
        logic [3:0] be = 4'b0000;
        int n = 1 << r.size;
        if (!legal_of(r)) return 4'b0000;
        for (int i = 0; i < n; i++) be[int'(r.addr[1:0]) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] wd_of(input rq_t r);
        logic [31:0] wd = '0;
        int n = 1 << r.size;
        if (!legal_of(r)) return '0;
        for (int k = 0; k < 4; k++) wd[8*k +: 8] = r.wdata[8*(k % n) +: 8];
        return wd;
    endfunction

    function automatic logic [31:0] rd_of(input rq_t r);
        logic [31:0] v = '0;
        int n = 1 << r.size;
        int base = int'(r.addr[11:0]);
        if (!legal_of(r) || r.we) return '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(base + i) & 4095];
        if (n < 4 && !r.uns && v[8*n-1])
            for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
        return v;
    endfunction

    task automatic commit(input rq_t r);
        int n = 1 << r.size;
        if (legal_of(r) && r.we)
            for (int i = 0; i < n; i++)
                ref_mem[(int'(r.addr[11:0]) + i) & 4095] = r.wdata[8*i +: 8];
    endtask

    function automatic logic [69:0] exp_mem(input bit gc, input bit gd, input rq_t r);
        bit g  = gc | gd;
        bit lg = legal_of(r);
        return {gc, gd, g & lg & ~r.we, g & lg & r.we, g ? r.addr[31:2] : 30'h0,
                g ? wd_of(r) : 32'h0, g ? be_of(r) : 4'h0};
    endfunction

    function automatic logic [33:0] exp_resp(input bit g, input rq_t r);
        return {g, g & ~legal_of(r), g ? rd_of(r) : 32'h0};
    endfunction

    function automatic logic [69:0] obs_mem();
        return {o_cg, o_dg, o_rd, o_wr, o_addr, o_wd, o_be};
    endfunction

    function automatic int mem_diffs();
        int nd = 0;
        for (int w = 0; w < 1024; w++)
            for (int k = 0; k < 4; k++)
                if (mem[w][8*k +: 8] !== ref_mem[4*w + k]) nd++;
        return nd;
    endfunction

    // One clock cycle of stimulus; combinational outputs sampled mid-cycle,
    // registered responses sampled just after the closing edge.
    task automatic step(input bit creq, input rq_t cr, input bit dreq, input rq_t dr);
        c_if.req = creq; c_if.we = cr.we; c_if.addr = cr.addr; c_if.size = cr.size;
        c_if.uns = cr.uns; c_if.wdata = cr.wdata;
        d_if.req = dreq; d_if.we = dr.we; d_if.addr = dr.addr; d_if.size = dr.size;
        d_if.uns = dr.uns; d_if.wdata = dr.wdata;
        @(negedge clk);
        o_cg = c_if.gnt; o_dg = d_if.gnt; o_rd = mem_read; o_wr = mem_write;
        o_addr = mem_addr; o_wd = mem_wdata; o_be = mem_byteen;
        @(posedge clk);
        #1;
        o_crv = c_if.rvalid; o_cerr = c_if.err; o_crd = c_if.rdata;
        o_drv = d_if.rvalid; o_derr = d_if.err; o_drd = d_if.rdata;
        $display("txn rst=%b req=%b%b gnt=%b%b rd=%b wr=%b addr=%h be=%b wd=%h | c:%b/%b/%h d:%b/%b/%h",
                 rst, creq, dreq, o_cg, o_dg, o_rd, o_wr, o_addr, o_be, o_wd,
                 o_crv, o_cerr, o_crd, o_drv, o_derr, o_drd);
    endtask

    rq_t idle;

    task automatic test_reset();
        rq_t sw = mk(1'b1, 32'h20, 2'd2, 1'b0, 32'hDEAD_BEEF);
        rq_t sb = mk(1'b1, 32'h25, 2'd0, 1'b0, 32'h0000_0077);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, sw, 1'b1, sb);
            n_vec++;
            if (obs_mem() !== exp_mem(1'b0, 1'b0, sw)) begin
                n_fail++;
                $display("FAIL reset_bus cyc%0d: got %h want %h", i, obs_mem(), exp_mem(1'b0, 1'b0, sw));
            end
            n_vec++;
            if ({o_crv, o_cerr, o_crd, o_drv, o_derr, o_drd} !== 68'h0) begin
                n_fail++;
                $display("FAIL reset_resp cyc%0d: got c=%b/%b/%h d=%b/%b/%h want zeros",
                         i, o_crv, o_cerr, o_crd, o_drv, o_derr, o_drd);
            end
        end
        rst = 1'b0;
        n_vec++;
        if (mem_diffs() !== 0) begin
            n_fail++;
            $display("FAIL reset_store_suppressed: %0d bytes differ, want 0", mem_diffs());
        end
    endtask

    task automatic test_directed();
        rq_t r;
        logic [32:0] want [6];
        rq_t seq [6];
        seq[0] = mk(1'b1, 32'h103, 2'd0, 1'b0, 32'h0000_00A5);
        seq[1] = mk(1'b0, 32'h103, 2'd0, 1'b0, 32'h0);
        seq[2] = mk(1'b0, 32'h103, 2'd0, 1'b1, 32'h0);
        seq[3] = mk(1'b1, 32'h10,  2'd2, 1'b0, 32'h8000_7FFF);
        seq[4] = mk(1'b0, 32'h12,  2'd1, 1'b0, 32'h0);
        seq[5] = mk(1'b0, 32'h10,  2'd1, 1'b1, 32'h0);
        want[0] = {1'b1, 32'h0};
        want[1] = {1'b1, 32'hFFFF_FFA5};
        want[2] = {1'b1, 32'h0000_00A5};
        want[3] = {1'b1, 32'h0};
        want[4] = {1'b1, 32'hFFFF_8000};
        want[5] = {1'b1, 32'h0000_7FFF};
        r = seq[0];
        step(1'b1, r, 1'b0, idle);
        n_vec++;
        if ({o_cg, o_wr, o_addr, o_be, o_wd} !== {1'b1, 1'b1, 30'h40, 4'b1000, 32'hA5A5_A5A5}) begin
            n_fail++;
            $display("FAIL sb_bus: got gnt=%b wr=%b addr=%h be=%b wd=%h want 1 1 040 1000 a5a5a5a5",
                     o_cg, o_wr, o_addr, o_be, o_wd);
        end
        commit(r);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                r = seq[i];
                step(1'b1, r, 1'b0, idle);
                commit(r);
            end
            n_vec++;
            if ({o_crv, o_crd} !== want[i] || o_cerr !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_resp%0d: got rvalid=%b err=%b rdata=%h want %b 0 %h",
                         i, o_crv, o_cerr, o_crd, want[i][32], want[i][31:0]);
            end
        end
    endtask

    task automatic test_errors();
        rq_t bad [4];
        bad[0] = mk(1'b0, 32'h6,  2'd2, 1'b0, 32'h0);
        bad[1] = mk(1'b1, 32'h5,  2'd1, 1'b0, 32'h1234_5678);
        bad[2] = mk(1'b0, 32'h8,  2'd3, 1'b0, 32'h0);
        bad[3] = mk(1'b1, 32'h22, 2'd2, 1'b0, 32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, idle, 1'b1, bad[i]);
            n_vec++;
            if ({o_dg, o_rd, o_wr, o_be} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
                n_fail++;
                $display("FAIL err_bus%0d: got gnt=%b rd=%b wr=%b be=%b want 1 0 0 0000",
                         i, o_dg, o_rd, o_wr, o_be);
            end
            n_vec++;
            if ({o_drv, o_derr, o_drd} !== {1'b1, 1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL err_resp%0d: got rvalid=%b err=%b rdata=%h want 1 1 0", i, o_drv, o_derr, o_drd);
            end
        end
        n_vec++;
        if (mem_diffs() !== 0) begin
            n_fail++;
            $display("FAIL err_mem_unchanged: %0d bytes differ, want 0", mem_diffs());
        end
    endtask

    task automatic test_arbitration();
        rq_t lc = mk(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
        rq_t ld = mk(1'b0, 32'h44, 2'd2, 1'b0, 32'h0);
        logic [1:0] want;
        rst = 1'b1;
        step(1'b0, idle, 1'b0, idle);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, lc, 1'b1, ld);
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
            n_vec++;
            if ({o_cg, o_dg} !== want || {o_crv, o_drv} !== want) begin
                n_fail++;
                $display("FAIL alternate%0d: got gnt=%b%b rvalid=%b%b want %b", i, o_cg, o_dg, o_crv, o_drv, want);
            end
        end
        step(1'b0, idle, 1'b1, ld);
        step(1'b0, idle, 1'b1, ld);
        step(1'b1, lc, 1'b1, ld);
        n_vec++;
        if ({o_cg, o_dg} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_hold_d: got gnt=%b%b want 10", o_cg, o_dg);
        end
        step(1'b1, lc, 1'b0, idle);
        step(1'b1, lc, 1'b0, idle);
        step(1'b1, lc, 1'b1, ld);
        n_vec++;
        if ({o_cg, o_dg} !== 2'b01) begin
            n_fail++;
            $display("FAIL prio_hold_c: got gnt=%b%b want 01", o_cg, o_dg);
        end
    endtask

    task automatic test_reset_mid();
        rq_t lc = mk(1'b0, 32'h103, 2'd0, 1'b1, 32'h0);
        rq_t ld = mk(1'b0, 32'h10,  2'd2, 1'b0, 32'h0);
        step(1'b1, lc, 1'b1, ld);   // core wins, debug now favoured
        step(1'b1, lc, 1'b0, idle);
        n_vec++;
        if ({o_crv, o_crd} !== {1'b1, rd_of(lc)}) begin
            n_fail++;
            $display("FAIL pre_reset_load: got rvalid=%b rdata=%h want 1 %h", o_crv, o_crd, rd_of(lc));
        end
        rst = 1'b1;
        step(1'b1, lc, 1'b1, ld);
        n_vec++;
        if (obs_mem() !== 70'h0 || {o_crv, o_drv} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset: got bus=%h rvalid=%b%b want all zero", obs_mem(), o_crv, o_drv);
        end
        rst = 1'b0;
        step(1'b1, lc, 1'b1, ld);
        n_vec++;
        if ({o_cg, o_dg} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_after_reset: got gnt=%b%b want 10", o_cg, o_dg);
        end
    endtask

    function automatic rq_t rand_req();
        rq_t r;
        int s = $urandom_range(0, 9);
        r.size  = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
        r.addr  = {$urandom(), 12'h0} | {20'h0, 12'($urandom_range(0, 4095))};
        if ($urandom_range(0, 4) != 0 && r.size != 2'd3)
            r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
        r.we    = $urandom_range(0, 1) == 1;
        r.uns   = $urandom_range(0, 1) == 1;
        r.wdata = $urandom();
        return r;
    endfunction

    task automatic test_back_to_back();
        bit  pc = 0, pd = 0, gc, gd, turn_d = 0;
        rq_t rc = idle, rdq = idle, g;
        logic [69:0] em;
        logic [33:0] ec, ed;
        rst = 1'b1;
        step(1'b0, idle, 1'b0, idle);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pc && $urandom_range(0, 9) < 7) begin pc = 1; rc  = rand_req(); end
            if (!pd && $urandom_range(0, 9) < 6) begin pd = 1; rdq = rand_req(); end
            gc = pc && (!pd || !turn_d);
            gd = pd && (!pc ||  turn_d);
            if (pc && pd) turn_d = gc;
            g  = gd ? rdq : rc;
            em = exp_mem(gc, gd, g);
            ec = exp_resp(gc, rc);
            ed = exp_resp(gd, rdq);
            step(pc, rc, pd, rdq);
            commit(g);
            n_vec++;
            if (obs_mem() !== em) begin
                n_fail++;
                $display("FAIL rand_bus%0d: got %h want %h", i, obs_mem(), em);
            end
            n_vec++;
            if ({o_crv, o_cerr, o_crd} !== ec || {o_drv, o_derr, o_drd} !== ed) begin
                n_fail++;
                $display("FAIL rand_resp%0d: got c=%h d=%h want c=%h d=%h",
                         i, {o_crv, o_cerr, o_crd}, {o_drv, o_derr, o_drd}, ec, ed);
            end
            if (gc) pc = 0;
            if (gd) pd = 0;
        end
        n_vec++;
        if (mem_diffs() !== 0) begin
            n_fail++;
            $display("FAIL rand_mem_contents: %0d bytes differ, want 0", mem_diffs());
        end
    endtask

    initial begin
        logic [31:0] v;
        idle = '0;
        for (int w = 0; w < 1024; w++) begin
            v = $urandom();
            mem[w] = v;
            for (int k = 0; k < 4; k++) ref_mem[4*w + k] = v[8*k +: 8];
        end
        rst = 1'b1;
        c_if.req = 1'b0; c_if.we = 1'b0; c_if.addr = '0; c_if.size = '0; c_if.uns = 1'b0; c_if.wdata = '0;
        d_if.req = 1'b0; d_if.we = 1'b0; d_if.addr = '0; d_if.size = '0; d_if.uns = 1'b0; d_if.wdata = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_errors();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port word-addressed data memory between two byte-addressed requesters: the core load/store path (port `c_`) and the debug/loader path (port `d_`). Arbitrates round-robin and converts byte address plus access size into word address, byte enables and lane-replicated store data. Returns aligned, sign- or zero-extended load data on a registered response one cycle after grant. Sits between the core and the data memory; the memory sees exactly one access per cycle.

## Interface
- `WIDTH`, 32: data and byte-address width; only 32 is supported.
- `MEM_AW`, 10: word-address bits actually decoded by the memory; upper word-address bits are passed through unchanged.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `c_req` / `d_req` in 1: access request; held with all request fields stable until the matching `gnt`.
- `c_we` / `d_we` in 1: 1 = store, 0 = load.
- `c_addr` / `d_addr` in WIDTH: byte address.
- `c_size` / `d_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `c_unsigned` / `d_unsigned` in 1: zero-extend loads (lbu/lhu); ignored for word and stores.
- `c_wdata` / `d_wdata` in WIDTH: store data, right-justified.
- `c_gnt` / `d_gnt` out 1: combinational; request accepted this cycle.
- `c_rvalid` / `d_rvalid` out 1: registered; response for the access granted in the previous cycle.
- `c_rdata` / `d_rdata` out WIDTH: registered load result; 0 for stores and errors.
- `c_err` / `d_err` out 1: registered; valid with `rvalid`; misaligned or reserved-size access.
- `mem_read` out 1: granted, legal load.
- `mem_write` out 1: granted, legal store.
- `mem_addr` out WIDTH-2: `addr[WIDTH-1:2]` of the granted requester.
- `mem_wdata` out WIDTH: lane-replicated store data.
- `mem_byteen` out 4: byte enables.
- `mem_rdata` in WIDTH: combinational read data for `mem_addr`.

## Operation
- **Arbitration:**
  - One requester active: it is granted.
  - Both active: grant goes to the port selected by the 1-bit `prio` register (0 = core, 1 = debug).
  - After any cycle where both requested, `prio` flips to the loser.
  - `prio` is unchanged when at most one port requested.
- **Legality:**
  - Error if size = 11.
  - Error if half and `addr[0]` = 1.
  - Error if word and `addr[1:0]` != 0.
  - An illegal access is still granted, but `mem_read` and `mem_write` stay 0.
- **Byte enables:**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
  - No access: `4'b0000`.
- **Store data:**
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: `wdata`.
- **Load data:**
  - `mem_rdata >> (8*addr[1:0])`, truncated to the access size.
  - Then sign-extended, or zero-extended when `unsigned` = 1.
  - Captured into the granted port's `rdata` register at the grant edge.
- Response registers of the non-granted port load `rvalid` = 0.
- When neither port is granted, all `mem_*` outputs are 0.

## Timing
- Grant and memory access happen in the same cycle, T.
- A store commits at the edge ending T.
- `rvalid`, `rdata` and `err` are asserted during T+1 for exactly one cycle.
- Latency is one cycle for every access, hit or error.
- Back-to-back grants to the same port are allowed; responses then arrive every cycle.
- No stall path exists: requesters must accept a response in the cycle it is presented.
- **While `rst` = 1:**
  - No grants are issued.
  - `mem_read`, `mem_write` and `mem_byteen` are 0.
- **After reset:**
  - `prio` = 0.
  - All `rvalid`, `err` and `rdata` are 0.
- Reset asserted in cycle T+1 of a pending response: the response is dropped, and `rvalid` is 0 after the edge.
- Reset during T while a store is presented: the store does not happen, since the grant is suppressed.

## Structure
- Shared package `lsu_pkg` holds:
  - `mem_size_e` enum (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_RSV`).
  - The `lsu_req_t` struct (we, addr, size, unsigned, wdata).
  - Byte-enable constants.
- The core LSU and the debug loader import the same package.
- One sub-module, `dmem_lane`: purely combinational. It computes legality, byte enables, store replication, and load extract/extend from (addr[1:0], size, unsigned, wdata, mem_rdata). It is instantiated once, on the muxed granted request.
- The top level holds the arbiter, the `prio` register and both response register sets.

## Test plan
- Core `sb` addr 0x0000_0103, wdata 0x0000_00A5 → `mem_addr` 0x40, `byteen` 0b1000, `mem_wdata` 0xA5A5_A5A5. Then core `lb` 0x103 → `c_rdata` 0xFFFF_FFA5; `lbu` → 0x0000_00A5; each with `c_rvalid` = 1 one cycle after `c_gnt`.
- Word 0x8000_7FFF stored at 0x10, then `lh` 0x12 → 0xFFFF_8000; `lhu` 0x10 → 0x0000_7FFF.
- `lw` addr 0x6, `sh` addr 0x5, and size = 11 → granted, `mem_read` = `mem_write` = 0, next cycle `err` = 1 and `rdata` = 0; memory contents unchanged.
- Both ports request continuously for 6 cycles after reset → grants alternate C, D, C, D, C, D; single-port requests never flip `prio`.
- `rst` pulsed in the cycle after a granted load → `rvalid` = 0 after the edge, no grant during reset, `prio` = 0 afterwards.
